// File: rtl/lead_one_pipe.sv
// Pipelined leading/trailing-one detector: one binary-search halving step per stage,
// producing floor-log2 index, zero flag and left-aligned fraction under valid/ready flow control.
module lead_one_pipe #(
  parameter  int DATA_W = 32,
  parameter  int FRAC_W = 8,
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_zero,
  output logic [FRAC_W-1:0] out_frac
);

  localparam int NS = IDX_W + 1;

  logic [NS-1:0]     vld_q,  vld_d;
  logic [NS-1:0]     mode_q, mode_d;
  logic [DATA_W-1:0] word_q [NS];
  logic [DATA_W-1:0] word_d [NS];
  logic [IDX_W-1:0]  cnt_q  [NS];
  logic [IDX_W-1:0]  cnt_d  [NS];

  logic [NS-1:0]     rdy;
  logic [DATA_W-1:0] rev_data;
  logic              found;

  // Stage k may load when any stage from k to the output is empty, or the output drains.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      rdy[k] = out_ready || ((vld_q >> k) != ({NS{1'b1}} >> k));
    end
  end

  assign in_ready = rdy[0];

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      rev_data[i] = in_data[DATA_W-1-i];
    end
  end

  always_comb begin
    int sh;
    sh     = 0;
    vld_d  = vld_q;
    mode_d = mode_q;
    for (int k = 0; k < NS; k++) begin
      word_d[k] = word_q[k];
      cnt_d[k]  = cnt_q[k];
    end

    // Trailing-one search reuses the leading-one datapath on the mirrored word.
    if (rdy[0]) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      word_d[0] = in_mode ? rev_data : in_data;
      cnt_d[0]  = '0;
    end

    for (int k = 1; k < NS; k++) begin
      if (rdy[k]) begin
        sh        = DATA_W >> k;
        vld_d[k]  = vld_q[k-1];
        mode_d[k] = mode_q[k-1];
        if ((word_q[k-1] >> (DATA_W - sh)) == '0) begin
          word_d[k] = word_q[k-1] << sh;
          cnt_d[k]  = cnt_q[k-1] + IDX_W'(sh);
        end else begin
          word_d[k] = word_q[k-1];
          cnt_d[k]  = cnt_q[k-1];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      // NOTE: the datapath registers are cleared too; outputs are gated by valid anyway,
      // but a defined reset value keeps simulation free of X on the observable ports.
      for (int k = 0; k < NS; k++) begin
        word_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      for (int k = 0; k < NS; k++) begin
        word_q[k] <= word_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // After full normalisation a non-zero word always has its MSB set.
  assign found     = word_q[NS-1][DATA_W-1];
  assign out_valid = vld_q[NS-1];
  assign out_zero  = out_valid && !found;

  always_comb begin
    out_index = '0;
    out_frac  = '0;
    if (out_valid && found) begin
      if (mode_q[NS-1]) begin
        out_index = cnt_q[NS-1];
      end else begin
        out_index = IDX_W'(DATA_W - 1) - cnt_q[NS-1];
        out_frac  = word_q[NS-1][DATA_W-2 -: FRAC_W];
      end
    end
  end

endmodule

// File: tb/tb_lead_one_pipe.sv
// Self-checking bench for lead_one_pipe: directed cases, back-to-back stream, backpressure,
// random flow control and mid-flight reset, scored against a bit-scan reference model.
module tb_lead_one_pipe;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 8;
  localparam int IDX_W  = 5;
  localparam int LAT    = 6;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              zero;
    logic [FRAC_W-1:0] frac;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_mode = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic              in_ready;
  logic              out_valid;
  logic [IDX_W-1:0]  out_index;
  logic              out_zero;
  logic [FRAC_W-1:0] out_frac;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  res_t exp_q[$];

  lead_one_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_zero  (out_zero),
    .out_frac  (out_frac)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain bit scan of the original word.
  function automatic res_t model(logic [DATA_W-1:0] d, logic m);
    res_t r;
    int   p;
    int   pos;
    r = '0;
    p = -1;
    if (d == '0) begin
      r.zero = 1'b1;
      return r;
    end
    if (!m) begin
      for (int i = 0; i < DATA_W; i++) if (d[i]) p = i;
      r.idx = IDX_W'(p);
      for (int j = 0; j < FRAC_W; j++) begin
        pos = p - 1 - j;
        if (pos >= 0) r.frac[FRAC_W-1-j] = d[pos];
      end
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) if (d[i]) p = i;
      r.idx = IDX_W'(p);
    end
    return r;
  endfunction

  // Scoreboard: every accepted word must come out once, in order, matching the model.
  always @(negedge clk) begin
    res_t e;
    res_t got;
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
      if (out_valid && out_ready) begin
        got = {out_index, out_zero, out_frac};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_output got=%h expected=none (cycle %0d)", got, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL sb_result got idx=%0d zero=%0b frac=%h expected idx=%0d zero=%0b frac=%h (cycle %0d)",
                     got.idx, got.zero, got.frac, e.idx, e.zero, e.frac, cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    checks++; if (out_zero  !== 1'b0) begin failures++; $display("FAIL reset_out_zero got=%b expected=0", out_zero); end
    checks++; if (out_index !== '0)   begin failures++; $display("FAIL reset_out_index got=%0d expected=0", out_index); end
    checks++; if (out_frac  !== '0)   begin failures++; $display("FAIL reset_out_frac got=%h expected=00", out_frac); end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b expected=1", in_ready); end
    repeat (8) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ignored_input got out_valid=%b expected=0", out_valid); end
  endtask

  task automatic test_single(input logic [DATA_W-1:0] d, input logic m,
                             input logic [IDX_W-1:0] e_idx, input logic e_zero,
                             input logic [FRAC_W-1:0] e_frac, input string name);
    int acc;
    int got;
    acc = -1;
    got = -1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = m;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && got < 0; i++) begin
      @(negedge clk);
      if (out_valid) got = cyc;
    end
    checks++;
    if (acc < 0 || got < 0 || got - acc !== LAT) begin
      failures++;
      $display("FAIL %s_latency got=%0d expected=%0d", name, got - acc, LAT);
    end
    checks++; if (out_index !== e_idx)  begin failures++; $display("FAIL %s_index got=%0d expected=%0d", name, out_index, e_idx); end
    checks++; if (out_zero  !== e_zero) begin failures++; $display("FAIL %s_zero got=%b expected=%b", name, out_zero, e_zero); end
    checks++; if (out_frac  !== e_frac) begin failures++; $display("FAIL %s_frac got=%h expected=%h", name, out_frac, e_frac); end
  endtask

  task automatic test_directed();
    test_single(32'h0000_0001, 1'b0, 5'd0,  1'b0, 8'h00, "msb_bit0");
    test_single(32'h8000_0000, 1'b0, 5'd31, 1'b0, 8'h00, "msb_bit31");
    test_single(32'h0000_0B00, 1'b0, 5'd11, 1'b0, 8'h60, "msb_0b00");
    test_single(32'h0000_0B00, 1'b1, 5'd8,  1'b0, 8'h00, "lsb_0b00");
    test_single(32'h0000_0000, 1'b0, 5'd0,  1'b1, 8'h00, "msb_zero");
    test_single(32'h0000_0000, 1'b1, 5'd0,  1'b1, 8'h00, "lsb_zero");
    test_single(32'h0000_0003, 1'b0, 5'd1,  1'b0, 8'h80, "msb_short_frac");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          @(posedge clk); #1;
          in_valid = 1'b1;
          in_data  = 32'(1) << k;
          in_mode  = k[0];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        int n;
        int first;
        int last;
        logic [IDX_W-1:0] e_idx;
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (out_valid) begin
            if (first < 0) first = cyc;
            last  = cyc;
            e_idx = n[IDX_W-1:0];
            checks++;
            if (out_index !== e_idx) begin
              failures++;
              $display("FAIL b2b_index got=%0d expected=%0d", out_index, e_idx);
            end
            n++;
          end
        end
        checks++; if (n !== 32) begin failures++; $display("FAIL b2b_count got=%0d expected=32", n); end
        checks++;
        if (last - first !== 31) begin
          failures++;
          $display("FAIL b2b_contiguous got span=%0d expected=31", last - first);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    int   acc_n;
    int   unstable;
    bit   have_snap;
    bit   accepted;
    logic [IDX_W+FRAC_W:0] snap;
    acc_n = 0; unstable = 0; have_snap = 1'b0; snap = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_mode   = 1'($urandom_range(0, 1));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (accepted) acc_n++;
      if (out_valid) begin
        if (!have_snap) begin
          snap = {out_index, out_zero, out_frac};
          have_snap = 1'b1;
        end else if ({out_index, out_zero, out_frac} !== snap) begin
          unstable++;
        end
      end
      @(posedge clk); #1;
      if (accepted) begin
        in_data = $urandom;
        in_mode = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    checks++; if (acc_n !== 6) begin failures++; $display("FAIL bp_accepted got=%0d expected=6", acc_n); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b expected=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b expected=1", out_valid); end
    checks++;
    if (!have_snap || unstable != 0) begin
      failures++;
      $display("FAIL bp_stable got changes=%0d seen=%0b expected changes=0 seen=1", unstable, have_snap);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (accepted) acc_n++;
      @(posedge clk); #1;
      if (accepted) begin
        in_data = $urandom;
        in_mode = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    checks++; if (acc_n !== 20) begin failures++; $display("FAIL bp_full_rate got=%0d expected=20", acc_n); end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bp_drain got pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || accepted) begin
        in_valid = 1'($urandom_range(0, 1));
        in_mode  = 1'($urandom_range(0, 1));
        in_data  = ($urandom_range(0, 15) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      end
      @(negedge clk);
      accepted = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_drain got pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int   stale;
    logic [DATA_W-1:0] d;
    res_t r;
    stale = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = $urandom | 32'h1;
      in_mode  = k[0];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_out_valid got=%b expected=0", out_valid); end
    checks++; if (out_zero  !== 1'b0) begin failures++; $display("FAIL mid_reset_out_zero got=%b expected=0", out_zero); end
    checks++; if (out_index !== '0)   begin failures++; $display("FAIL mid_reset_out_index got=%0d expected=0", out_index); end
    checks++; if (out_frac  !== '0)   begin failures++; $display("FAIL mid_reset_out_frac got=%h expected=00", out_frac); end
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_reset_stale got=%0d expected=0", stale); end
    d = 32'h0004_2A00;
    r = model(d, 1'b0);
    test_single(d, 1'b0, r.idx, r.zero, r.frac, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL final_pending got=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
